hazard_scoreboard: RTL and testbench

Parametrised decode-stage hazard unit for the pipelined core, replacing fixed compare-against-EX/MEM hazard detection with a per-register scoreboard of in-flight writes. Each architectural register has a countdown of cycles until its pending result reaches the register file. Decode is stalled while any source it reads is still pending. An optional forwarding mode reduces stalls to the load-use bubble, and a saturating counter reports total stall cycles for performance measurement.

---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode hazard scoreboard: per-register writeback countdown, stall on pending sources; HAZARD_FWD_EN limits stalls to load-use.
// stall/busy combinational same cycle, scoreboard and stall_cnt update next clk; stall holds decode, nothing issues.
module hazard_scoreboard #(
   parameter int REG_ADDR_W  = 3,
   parameter int WB_LAT      = 3,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid,
   input  logic [REG_ADDR_W-1:0]  rs,
   input  logic                   rs_read,
   input  logic [REG_ADDR_W-1:0]  rt,
   input  logic                   rt_read,
   input  logic [REG_ADDR_W-1:0]  rd,
   input  logic                   rd_write,
   input  logic                   rd_load,
   input  logic                   flush,
   output logic                   stall,
   output logic                   busy,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int NREG = 1 << REG_ADDR_W;
   localparam int CW   = $clog2(WB_LAT + 1);
   localparam logic [CW-1:0] LAT = CW'(WB_LAT);

   logic [CW-1:0]          cnt_q [NREG];
   logic [CW-1:0]          cnt_d [NREG];
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   haz_rs, haz_rt, issue;

`ifdef HAZARD_FWD_EN
   logic [NREG-1:0] ld_q, ld_d;

   // Only the cycle right after a load issues lacks forwardable data.
   always_comb begin
      haz_rs = ld_q[rs] && (cnt_q[rs] == LAT);
      haz_rt = ld_q[rt] && (cnt_q[rt] == LAT);
   end
`else
   logic unused_rd_load;
   assign unused_rd_load = rd_load;

   // The final count (1) is the register-file write cycle; decode reads it through the write-through path.
   always_comb begin
      haz_rs = cnt_q[rs] > CW'(1);
      haz_rt = cnt_q[rt] > CW'(1);
   end
`endif

   assign stall = valid && !flush && ((rs_read && haz_rs) || (rt_read && haz_rt));
   assign issue = valid && !flush && !stall && !rst;

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         busy     = busy || (cnt_q[i] != '0);
         cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
      end
      if (issue && rd_write) begin
         cnt_d[rd] = LAT;
      end
   end

`ifdef HAZARD_FWD_EN
   always_comb begin
      ld_d = '0;
      for (int i = 0; i < NREG; i++) begin
         ld_d[i] = (cnt_q[i] > CW'(1)) ? ld_q[i] : 1'b0;
      end
      if (issue && rd_write) begin
         ld_d[rd] = rd_load;
      end
   end
`endif

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         stall_cnt_q <= '0;
`ifdef HAZARD_FWD_EN
         ld_q <= '0;
`endif
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stall_cnt_q <= stall_cnt_d;
`ifdef HAZARD_FWD_EN
         ld_q <= ld_d;
`endif
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a cycle-timestamp reference model.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int LAT   = 3;
   localparam int S_LAT = 15;
   localparam int NEVER = -1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // main DUT
   logic       rst, valid, rs_read, rt_read, rd_write, rd_load, flush;
   logic [2:0] rs, rt, rd;
   logic       stall, busy;
   logic [15:0] stall_cnt;

   hazard_scoreboard #(.REG_ADDR_W(3), .WB_LAT(LAT), .STALL_CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .valid(valid), .rs(rs), .rs_read(rs_read),
      .rt(rt), .rt_read(rt_read), .rd(rd), .rd_write(rd_write), .rd_load(rd_load),
      .flush(flush), .stall(stall), .busy(busy), .stall_cnt(stall_cnt));

   // saturation DUT: long latency keeps decode stalled most cycles
   logic        s_rst, s_valid;
   logic        s_stall, s_busy;
   logic [15:0] s_stall_cnt;

   hazard_scoreboard #(.REG_ADDR_W(3), .WB_LAT(S_LAT), .STALL_CNT_W(16)) u_sat (
      .clk(clk), .rst(s_rst), .valid(s_valid), .rs(3'd1), .rs_read(1'b1),
      .rt(3'd0), .rt_read(1'b0), .rd(3'd1), .rd_write(1'b1), .rd_load(1'b1),
      .flush(1'b0), .stall(s_stall), .busy(s_busy), .stall_cnt(s_stall_cnt));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: each register remembers the cycle its latest producer issued.
   int m_last [8];
   bit m_ld   [8];
   int m_cyc;
   int m_scnt;

   function automatic bit m_haz(input int r);
      if (FWD) return m_ld[r] && (m_cyc == m_last[r] + 1);
      return m_cyc < m_last[r] + LAT;
   endfunction

   function automatic bit m_busy();
      for (int r = 0; r < 8; r++) if (m_cyc <= m_last[r] + LAT) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < 8; r++) begin
         m_last[r] = NEVER;
         m_ld[r]   = 1'b0;
      end
      m_scnt = 0;
   endtask

   task automatic step(input bit v, input int a_rs, input bit a_rsr, input int a_rt, input bit a_rtr,
                       input int a_rd, input bit a_rdw, input bit a_rdl, input bit a_fl, input bit a_rst,
                       output bit st);
      bit e_stall;
      @(negedge clk);
      valid = v; rs = 3'(a_rs); rs_read = a_rsr; rt = 3'(a_rt); rt_read = a_rtr;
      rd = 3'(a_rd); rd_write = a_rdw; rd_load = a_rdl; flush = a_fl; rst = a_rst;
      #1;
      e_stall = v && !a_fl && ((a_rsr && m_haz(a_rs)) || (a_rtr && m_haz(a_rt)));
      check("stall", 32'(stall), 32'(e_stall));
      check("busy", 32'(busy), 32'(m_busy()));
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      st = stall;
      if (a_rst) begin
         m_clear();
      end else begin
         if (e_stall && m_scnt < 65535) m_scnt++;
         if (v && !a_fl && !e_stall && a_rdw) begin
            m_last[a_rd] = m_cyc;
            m_ld[a_rd]   = a_rdl;
         end
      end
      m_cyc++;
   endtask

   task automatic do_reset();
      bit st;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, st);
   endtask

   // Hold a reader of register r valid until it issues; returns the stall count (bounded).
   task automatic read_until_issue(input string tag, input int r, input bit use_rt, output int n);
      bit st;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         step(1, use_rt ? 0 : r, !use_rt, use_rt ? r : 0, use_rt, 0, 0, 0, 0, 0, st);
         if (!st) return;
         n++;
      end
      check({tag, "_timeout"}, 32'(n), 32'(0));
   endtask

   task automatic main_seq();
      bit st;
      int n;
      // load-use / plain RAW on R2
      do_reset();
      step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, st);
      read_until_issue("raw_r2", 2, 0, n);
      check("raw_r2_stalls", 32'(n), FWD ? 32'd0 : 32'd2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
      check("raw_r2_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd2);
      // WAW restart on R1
      do_reset();
      step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, st);
      step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, st);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
         if (busy) n++;
      end
      check("waw_busy_cycles", 32'(n), 32'd3);
      // load producer R4 read via rt, ALU producer R5
      do_reset();
      step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, st);
      read_until_issue("load_r4", 4, 1, n);
      check("load_use_stalls", 32'(n), FWD ? 32'd1 : 32'd2);
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, st);
      read_until_issue("alu_r5", 5, 0, n);
      check("alu_use_stalls", 32'(n), FWD ? 32'd0 : 32'd2);
      // flush: reader of pending R3 and writer of R6 under flush
      do_reset();
      step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, st);
      step(1, 3, 1, 3, 1, 6, 1, 1, 1, 0, st);
      check("flush_stall", 32'(st), 32'd0);
      step(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, st);
      check("flush_no_r6", 32'(st), 32'd0);
      // self dependency R7 <= R7 op R0
      do_reset();
      step(1, 7, 1, 0, 1, 7, 1, 0, 0, 0, st);
      check("self_dep_stall", 32'(st), 32'd0);
      step(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, st);
      check("self_dep_next", 32'(st), FWD ? 32'd0 : 32'd1);
      check("self_dep_busy", 32'(busy), 32'd1);
      // random traffic
      for (int k = 0; k < 1500; k++) begin
         step($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(1, 0),
              $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
              $urandom_range(2, 0) != 0, $urandom_range(1, 0),
              $urandom_range(7, 0) == 0, $urandom_range(63, 0) == 0, st);
      end
   endtask

   task automatic sat_seq();
      int  s_last = NEVER;
      int  s_cyc  = 0;
      int  s_scnt = 0;
      bit  e_stall;
      for (int k = 0; k < 70300; k++) begin
         @(negedge clk);
         s_valid = 1'b1; s_rst = 1'b0;
         #1;
         e_stall = FWD ? (s_cyc == s_last + 1) : (s_cyc < s_last + S_LAT);
         if (s_stall !== e_stall) check("sat_stall", 32'(s_stall), 32'(e_stall));
         if (e_stall) begin
            if (s_scnt < 65535) s_scnt++;
         end else begin
            s_last = s_cyc;
         end
         s_cyc++;
      end
      @(negedge clk);
      #1;
      check("sat_cnt", 32'(s_stall_cnt), 32'(s_scnt));
      check("sat_cnt_max", 32'(s_stall_cnt), FWD ? 32'(s_scnt) : 32'd65535);
      e_stall = FWD ? (s_cyc == s_last + 1) : (s_cyc < s_last + S_LAT);
      s_rst = 1'b1;
      #1;
      check("sat_rst_stall", 32'(s_stall), 32'(e_stall));
      @(negedge clk);
      s_rst = 1'b0; s_valid = 1'b0;
      #1;
      check("sat_rst_cnt", 32'(s_stall_cnt), 32'd0);
      check("sat_rst_busy", 32'(s_busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; rs = '0; rs_read = 1'b0; rt = '0; rt_read = 1'b0;
      rd = '0; rd_write = 1'b0; rd_load = 1'b0; flush = 1'b0;
      s_rst = 1'b1; s_valid = 1'b0;
      m_cyc = 0;
      m_clear();
      @(posedge clk);
      fork
         main_seq();
         sat_seq();
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
